// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit slice.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit unsigned adder with carry in/out.
module adder_4bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                overflow
);

    // Widen before adding so the carry out lands in the top bit.
    assign {overflow, sum} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(carry_in);

endmodule

// File: rtl/adder_nibble_serial.sv
// Multi-cycle wide unsigned adder: feeds one nibble pair per clock into a
// single adder_4bit, LSB first, chaining the carry through a register.
module adder_nibble_serial
    import adder_pkg::*;
#(
    parameter int NUM_NIBBLES = 4,
    localparam int W          = NIBBLE_W * NUM_NIBBLES
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         overflow
);

    // A single-nibble design still gets a 1-bit index so the vector is legal.
    localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    adder_state_t                          state;
    logic [IDX_W-1:0]                      idx;
    logic                                  carry_q;
    logic                                  ovf_q;
    logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0]  a_q;
    logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0]  b_q;
    logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0]  sum_q;

    logic [NIBBLE_W-1:0]                   nib_sum;
    logic                                  nib_ovf;
    logic                                  accept;

    // The slice being worked on is selected by idx; carry comes from the previous edge.
    adder_4bit u_adder (
        .a        (a_q[idx]),
        .b        (b_q[idx]),
        .carry_in (carry_q),
        .sum      (nib_sum),
        .overflow (nib_ovf)
    );

    assign accept   = start && (state == IDLE || state == DONE);
    assign busy     = (state == ADD);
    assign done     = (state == DONE);
    assign sum      = sum_q;
    assign overflow = ovf_q;

    // Control FSM, nibble index, operand capture and result assembly.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            state   <= ADD;
            idx     <= '0;
            carry_q <= carry_in;
            ovf_q   <= 1'b0;
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
        end else begin
            case (state)
                ADD: begin
                    sum_q[idx] <= nib_sum;
                    carry_q    <= nib_ovf;
                    if (idx == LAST_IDX) begin
                        // Wrap idx here so it never reaches NUM_NIBBLES.
                        state <= DONE;
                        idx   <= '0;
                        ovf_q <= nib_ovf;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_nibble_serial.sv
// Self-checking bench for adder_nibble_serial (NUM_NIBBLES = 4).
module tb_adder_nibble_serial;

    localparam int N = 4;
    localparam int W = 4 * N;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    adder_nibble_serial #(.NUM_NIBBLES(N)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, result is {overflow, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
    endfunction

    // Starts one op and waits for done. lat = edges after the accept edge until done
    // is seen; bcnt = sampled cycles with busy high. Returns lat = TMO on timeout.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input bit hold, output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; carry_in = ci; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < TMO) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0; start = 1'b1; a = 16'hAAAA; b = 16'h5555; carry_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done, sum, overflow} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: busy=%b done=%b sum=%h ovf=%b, want all 0",
                         i, busy, done, sum, overflow);
            end
        end
        // Release with start still high: the first live edge accepts.
        @(negedge clk); n_rst = 1'b1; a = 16'h0003; b = 16'h0004; carry_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_accept: busy=%b, want 1", busy);
        end
        repeat (N) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || sum !== 16'h0007 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_result: done=%b sum=%h ovf=%b, want 1 0007 0",
                     done, sum, overflow);
        end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [W-1:0] held;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bcnt);
        n_checks++;
        if (lat !== N) begin
            n_fail++;
            $display("FAIL basic_latency: %0d edges, want %0d", lat, N);
        end
        n_checks++;
        if (bcnt !== N) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: %0d, want %0d", bcnt, N);
        end
        n_checks++;
        if (sum !== 16'h5555 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: sum=%h ovf=%b, want 5555 0", sum, overflow);
        end
        // done is a single-cycle pulse and the result holds afterwards.
        held = sum;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== held || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b busy=%b sum=%h ovf=%b, want 0 0 %h 0",
                     done, busy, sum, overflow, held);
        end
    endtask

    task automatic test_carry;
        int lat, bcnt;
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, bcnt);
        n_checks++;
        if (lat !== N || sum !== 16'h0000 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_ripple1: lat=%0d sum=%h ovf=%b, want %0d 0000 1",
                     lat, sum, overflow, N);
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat, bcnt);
        n_checks++;
        if (lat !== N || sum !== 16'hFFFF || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_ripple2: lat=%0d sum=%h ovf=%b, want %0d FFFF 1",
                     lat, sum, overflow, N);
        end
    endtask

    task automatic test_ignored_inputs;
        int lat;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        // Disturb operands and request a new op for the first two ADD cycles.
        @(negedge clk); a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        #1;
        lat = 3;
        // Sample after each remaining edge until done.
        @(posedge clk); #1;
        while (!done && lat < TMO) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ignored_busy lat=%0d: busy=%b, want 1", lat, busy);
            end
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== N || sum !== 16'h0002 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_result: lat=%0d sum=%h ovf=%b, want %0d 0002 0",
                     lat, sum, overflow, N);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_no_restart: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt, gap;
        logic [W:0] exp;
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, lat, bcnt);
        n_checks++;
        if (lat !== N || {overflow, sum} !== 17'h1_0000) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d got=%h, want %0d 10000", lat, {overflow, sum}, N);
        end
        // Still in the DONE cycle: present the next operands, start stays high.
        a = 16'h0F0F; b = 16'hF0F0; carry_in = 1'b1;
        exp = model(16'h0F0F, 16'hF0F0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        while (!done && gap < TMO) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_no_idle gap=%0d: busy=%b, want 1", gap, busy);
            end
            @(posedge clk); #1;
            gap++;
        end
        n_checks++;
        if (gap !== N + 1 || {overflow, sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: gap=%0d got=%h, want %0d %h", gap, {overflow, sum}, N + 1, exp);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat, bcnt;
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);            // accept
        @(negedge clk); start = 1'b0;
        @(posedge clk);            // first ADD edge
        @(negedge clk); n_rst = 1'b0;
        @(posedge clk); #1;        // second ADD edge, reset wins
        n_checks++;
        if ({busy, done, sum, overflow} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy=%b done=%b sum=%h ovf=%b, want all 0",
                     busy, done, sum, overflow);
        end
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
        n_checks++;
        if (lat !== N || {overflow, sum} !== model(16'h00FF, 16'h0001, 1'b0)
            || sum !== 16'h0100) begin
            n_fail++;
            $display("FAIL midrst_next: lat=%0d got=%h, want %0d 00100", lat, {overflow, sum}, N);
        end
    endtask

    task automatic test_random;
        int lat, bcnt;
        logic [W-1:0] x, y;
        logic ci;
        logic [W:0] exp;
        for (int i = 0; i < 25; i++) begin
            x   = W'($urandom);
            y   = W'($urandom);
            ci  = 1'($urandom_range(0, 1));
            exp = model(x, y, ci);
            run_op(x, y, ci, 1'b0, lat, bcnt);
            n_checks++;
            if (lat !== N || bcnt !== N || {overflow, sum} !== exp) begin
                n_fail++;
                $display("FAIL random%0d: %h+%h+%b lat=%0d busy=%0d got=%h, want %0d %0d %h",
                         i, x, y, ci, lat, bcnt, {overflow, sum}, N, N, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ignored_inputs;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
